// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU native interface and the
// debug unit's memory-access port. Round-robin on conflicts, grant held until
// the memory completes, one-cycle ready pulse back to the owner.
// Optional build macro MEM_ARB_TIMEOUT_EN adds an access timeout with a sticky
// error flag; without it an access waits indefinitely and timeout_err is 0.
module mem_arbiter #(
    parameter int unsigned DBG_FIRST      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dbg_op,
    input  logic        dbg_rw,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rdy,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CPU_ACC = 2'd1;
    localparam logic [1:0] ST_DBG_ACC = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Pretend the other side was granted last so DBG_FIRST wins the first conflict.
    localparam logic LAST_DBG_INIT = (DBG_FIRST == 0) ? 1'b1 : 1'b0;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_rdy_q, dbg_rdy_d;
    logic [1:0]  owner_q, owner_d;
    logic        last_dbg_q, last_dbg_d;
    logic        pick_dbg;
    logic        acc_done;
    logic [31:0] acc_data;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    // Next-state: arbitration in IDLE, completion/abort in the access states.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        dbg_rdy_d   = 1'b0;
        owner_d     = owner_q;
        last_dbg_d  = last_dbg_q;
        acc_done    = 1'b0;
        acc_data    = mem_rdata;
        // Debug wins if alone, or on a conflict when CPU was granted last.
        pick_dbg    = dbg_op && (!cpu_valid || !last_dbg_q);
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid || dbg_op) begin
                    mem_valid_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                    if (pick_dbg) begin
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                        mem_wstrb_d = dbg_rw ? 4'h0 : 4'hF;
                        owner_d     = 2'b10;
                        last_dbg_d  = 1'b1;
                        state_d     = ST_DBG_ACC;
                    end else begin
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_wstrb_d = cpu_wstrb;
                        owner_d     = 2'b01;
                        last_dbg_d  = 1'b0;
                        state_d     = ST_CPU_ACC;
                    end
                end
            end
            ST_CPU_ACC, ST_DBG_ACC: begin
                if (mem_ready) begin
                    acc_done = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 == TIMEOUT_VAL) begin
                    acc_done      = 1'b1;
                    acc_data      = 32'hDEADBEEF;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                if (acc_done) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_DONE;
                    if (state_q == ST_CPU_ACC) begin
                        cpu_rdata_d = acc_data;
                        cpu_ready_d = 1'b1;
                    end else begin
                        dbg_rdata_d = acc_data;
                        dbg_rdy_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Bubble so the finished requester can drop its request.
                owner_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            cpu_rdata_q <= 32'd0;
            cpu_ready_q <= 1'b0;
            dbg_rdata_q <= 32'd0;
            dbg_rdy_q   <= 1'b0;
            owner_q     <= 2'b00;
            last_dbg_q  <= LAST_DBG_INIT;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_rdy_q   <= dbg_rdy_d;
            owner_q     <= owner_d;
            last_dbg_q  <= last_dbg_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_rdy   = dbg_rdy_q;
    assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single on-chip memory port between the picorv32 native memory interface and the debug unit's memory-access port.
- Grants one requester at a time and holds the grant until the memory completes.
- Returns read data and a one-cycle ready pulse to the owner.
- Sits between the CPU/debug unit and the memory/peripheral decoder in the SoC top level.

Parameters:
- DBG_FIRST, 1: requester that wins the first simultaneous request after reset (1 = debug, 0 = CPU).
- TIMEOUT_CYCLES, 255: cycles without mem_ready before a granted access is aborted (used only with MEM_ARB_TIMEOUT_EN); 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock
- n_reset  in  1  synchronous, active-low reset
- cpu_valid  in  1  CPU request; held until cpu_ready
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_wstrb  in  4  CPU byte strobes; 0 = read
- cpu_rdata  out  32  read data to CPU; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse to CPU
- dbg_op  in  1  debug request; held until dbg_rdy
- dbg_rw  in  1  1 = read, 0 = write (word access)
- dbg_addr  in  32  debug address
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  read data to debug unit; valid while dbg_rdy=1
- dbg_rdy  out  1  one-cycle completion pulse to debug unit
- mem_valid  out  1  memory request
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte strobes
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completion, sampled while mem_valid=1
- owner  out  2  00 none, 01 CPU, 10 debug
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset, synchronous on n_reset=0: state IDLE.
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - cpu_ready=0, dbg_rdy=0, cpu_rdata=0, dbg_rdata=0.
  - owner=00, timeout_err=0.
  - last-grant pointer initialised so DBG_FIRST wins the first conflict.
- Reset during an access abandons it: mem_valid drops the next edge and no ready pulse is issued.
- All outputs are registered.
- States:
  - IDLE: if cpu_valid or dbg_op is high, pick a winner and latch its addr/wdata/strobes into the mem_* registers. Set mem_valid=1 and owner, then go to CPU_ACC or DBG_ACC. Latency from request sampled to mem_valid high is 1 cycle.
  - Arbitration: with a single requester, it wins. If both are high, the requester not granted last wins (round-robin), and the first conflict after reset goes to DBG_FIRST.
  - Debug strobes: write gives mem_wstrb=4'hF; read gives 4'h0.
  - CPU_ACC / DBG_ACC: outputs held stable. When mem_valid & mem_ready: mem_valid<=0, mem_rdata copied to the owner's rdata, owner's ready<=1 for exactly one cycle, go to DONE. The other requester's ready stays 0.
  - DONE: one mandatory cycle; ready cleared, owner=00, go to IDLE. This bubble lets the finishing requester drop its request before re-arbitration, so no access is duplicated.
- Back-to-back: minimum 3 cycles between consecutive mem_valid rising edges when the memory answers in 1 cycle.
- Request inputs are ignored while not in IDLE. Requester signal changes during its own access are not re-latched.
- mem_ready while mem_valid=0 is ignored.
- Write accesses still copy mem_rdata to the owner's rdata; the requester ignores it.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on grant and increments each cycle in CPU_ACC/DBG_ACC without mem_ready.
  - When it reaches TIMEOUT_CYCLES, the access aborts: mem_valid<=0, owner's rdata<=32'hDEADBEEF, owner's ready pulses once, timeout_err<=1 (sticky until reset), go to DONE.
  - mem_ready arriving on the same edge as the timeout wins: normal completion, no error.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; an access waits indefinitely.
  - timeout_err is tied 0.

Test Plan:
- CPU read, cpu_addr=0x100, memory ready 2 cycles after mem_valid with rdata 0x12345678 -> mem_addr=0x100, mem_wstrb=0; cpu_ready pulses 1 cycle with cpu_rdata=0x12345678; dbg_rdy stays 0.
- Debug write, dbg_rw=0, dbg_addr=0x200, dbg_wdata=0xCAFEF00D -> mem_wstrb=4'hF, mem_wdata=0xCAFEF00D; single dbg_rdy pulse; owner returns to 00 after DONE.
- cpu_valid and dbg_op raised on the same edge after reset, DBG_FIRST=1 -> debug is served first, then CPU. Both held high continuously -> grants alternate D,C,D,C over 4 accesses.
- Memory with 1-cycle ready and CPU re-requesting immediately after cpu_ready -> exactly one mem_valid per CPU request; mem_valid rising edges at least 3 cycles apart.
- n_reset asserted while in DBG_ACC -> next edge mem_valid=0 and owner=00; no dbg_rdy; a fresh request afterwards completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted on a CPU read -> cpu_ready pulses with cpu_rdata=0xDEADBEEF; timeout_err=1 and remains set across later good accesses.
